// File: rtl/quad_pkg.sv
// Shared types, Gray-code constants and transition helpers for the quadrature decoder.
package quad_pkg;

  typedef enum logic {S_INIT, S_TRACK} qd_state_t;

  typedef logic [1:0] qphase_t;

  // Phase codes are {A,B}; up runs 00->10->11->01->00.
  localparam qphase_t Q_00 = 2'b00;
  localparam qphase_t Q_10 = 2'b10;
  localparam qphase_t Q_11 = 2'b11;
  localparam qphase_t Q_01 = 2'b01;

  function automatic logic is_up(qphase_t prev, qphase_t cur);
    logic r;
    case (prev)
      Q_00:    r = (cur == Q_10);
      Q_10:    r = (cur == Q_11);
      Q_11:    r = (cur == Q_01);
      default: r = (cur == Q_00);
    endcase
    return r;
  endfunction

  function automatic logic is_down(qphase_t prev, qphase_t cur);
    logic r;
    case (prev)
      Q_00:    r = (cur == Q_01);
      Q_01:    r = (cur == Q_11);
      Q_11:    r = (cur == Q_10);
      default: r = (cur == Q_00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder phase: multi-flop synchroniser followed by a debounce filter that
// accepts a new level only after DEB_CYCLES consecutive differing synced samples.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic filt,
  output logic accept,
  output logic settled
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt;
  logic [SW-1:0]          stab;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign settled = (stab == STAB_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      filt   <= 1'b0;
      cnt    <= '0;
      stab   <= '0;
      accept <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      accept <= 1'b0;
      if (synced == filt) begin
        cnt <= '0;
        if (stab != STAB_MAX) stab <= stab + 1'b1;
      end else begin
        stab <= '0;
        if (cnt == CNT_LAST) begin
          filt   <= synced;
          cnt    <= '0;
          accept <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder front end: filtered A/B phases are decoded into step/dir
// pulses, a wrap-around position count and a sticky illegal-transition flag.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  input  logic             err_clr,
  output logic             step,
  output logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  logic filt_a, filt_b, acc_a, acc_b, set_a, set_b;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_filt_a (
    .clk(clk), .reset(reset), .din(a_in),
    .filt(filt_a), .accept(acc_a), .settled(set_a)
  );

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_filt_b (
    .clk(clk), .reset(reset), .din(b_in),
    .filt(filt_b), .accept(acc_b), .settled(set_b)
  );

  qd_state_t        state, state_n;
  qphase_t          q_cur, q_d, qp, qp_n;
  logic             step_n, dir_n, err_n, err_set;
  logic [CNT_W-1:0] count_n;

  assign q_cur = {filt_a, filt_b};

  // q_d is one decode pipeline stage between the filters and the transition compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      q_d   <= Q_00;
      qp    <= Q_00;
      step  <= 1'b0;
      dir   <= 1'b0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      q_d   <= q_cur;
      qp    <= qp_n;
      step  <= step_n;
      dir   <= dir_n;
      count <= count_n;
      err   <= err_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    qp_n    = qp;
    step_n  = 1'b0;
    dir_n   = dir;
    count_n = count;
    err_set = 1'b0;
    case (state)
      S_INIT: begin
        // Adopt the encoder position silently once it is known.
        if (acc_a || acc_b || (set_a && set_b)) begin
          qp_n    = q_cur;
          state_n = S_TRACK;
        end
      end
      S_TRACK: begin
        if (q_d != qp) begin
          qp_n = q_d;
          if (is_up(qp, q_d)) begin
            step_n  = 1'b1;
            dir_n   = 1'b1;
            count_n = count + 1'b1;
          end else if (is_down(qp, q_d)) begin
            step_n  = 1'b1;
            dir_n   = 1'b0;
            count_n = count - 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_n = S_INIT;
    endcase
    if (clr) count_n = '0;
    err_n = err_set ? 1'b1 : (err_clr ? 1'b0 : err);
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: directed table, corner sequences,
// and randomized encoder motion against an index-arithmetic position model.
module tb_quadrature_decoder;
  import quad_pkg::*;

  logic       clk = 1'b0;
  logic       reset, a_in, b_in, clr, err_clr;
  logic       step, dir, err;
  logic [3:0] count;

  always #5 clk = ~clk;

  quadrature_decoder dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .clr(clr), .err_clr(err_clr),
    .step(step), .dir(dir), .count(count), .err(err)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_cnt = 0;
  logic last_dir = 1'b0;

  always @(negedge clk) begin
    if (step === 1'b1) begin
      step_cnt++;
      last_dir = dir;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Position model: encoder phase index 0..3 maps to Gray code {A,B}.
  logic [1:0] gray_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int pidx;

  task automatic apply_phase(input int idx);
    logic [1:0] g;
    g = gray_tab[idx % 4];
    a_in = g[1];
    b_in = g[0];
  endtask

  typedef struct {
    int   move;
    int   exp_count;
    logic exp_dir;
  } vec_t;

  vec_t vecs [21];

  initial begin
    int s0, m_count, hold, r, mv, exp_steps;
    logic m_err;

    vecs = '{'{1, 2, 1}, '{1, 3, 1}, '{1, 4, 1}, '{1, 5, 1}, '{1, 6, 1},
             '{1, 7, 1}, '{1, 8, 1}, '{1, 9, 1}, '{1, 10, 1}, '{1, 11, 1},
             '{1, 12, 1}, '{1, 13, 1}, '{1, 14, 1}, '{1, 15, 1}, '{1, 0, 1},
             '{-1, 15, 0}, '{1, 0, 1}, '{-1, 15, 0}, '{-1, 14, 0},
             '{-1, 13, 0}, '{-1, 12, 0}};

    // Reset with both phases high, then release: position adopted silently.
    reset = 1'b1; a_in = 1'b1; b_in = 1'b1; clr = 1'b0; err_clr = 1'b0;
    tick(3);
    check("reset_step", step, 0);
    check("reset_dir", dir, 0);
    check("reset_count", count, 0);
    check("reset_err", err, 0);
    reset = 1'b0;
    s0 = step_cnt;
    tick(20);
    check("init11_steps", step_cnt - s0, 0);
    check("init11_err", err, 0);
    check("init11_count", count, 0);

    // Re-reset at 00: settled path must enter tracking.
    reset = 1'b1; a_in = 1'b0; b_in = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(20);
    check("init00_state", 32'(dut.state), 32'(S_TRACK));
    check("init00_count", count, 0);

    // First up edge: step must appear exactly 7 cycles after first sampling edge.
    pidx = 1;
    apply_phase(pidx);
    s0 = step_cnt;
    tick(7);
    check("latency_early", step_cnt - s0, 0);
    tick(1);
    check("latency_step", step, 1);
    check("latency_dir", dir, 1);
    tick(2);
    check("first_count", count, 1);

    for (int i = 0; i < 21; i++) begin
      pidx = (pidx + 4 + vecs[i].move) % 4;
      apply_phase(pidx);
      s0 = step_cnt;
      tick(10);
      check($sformatf("vec%0d_steps", i), step_cnt - s0, 1);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("vec%0d_dir", i), dir, vecs[i].exp_dir);
      check($sformatf("vec%0d_err", i), err, 0);
    end

    // Two-cycle glitch on A at phase 00 is rejected.
    s0 = step_cnt;
    a_in = 1'b1;
    tick(2);
    a_in = 1'b0;
    tick(20);
    check("glitch_steps", step_cnt - s0, 0);
    check("glitch_count", count, 12);

    // Illegal 00->11, then 11->00 together with err_clr: set wins.
    pidx = 2;
    apply_phase(pidx);
    s0 = step_cnt;
    tick(12);
    check("illegal1_err", err, 1);
    check("illegal1_count", count, 12);
    check("illegal1_steps", step_cnt - s0, 0);
    pidx = 0;
    apply_phase(pidx);
    tick(7);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("illegal2_setwins", err, 1);
    tick(4);
    check("illegal2_err_held", err, 1);
    check("illegal2_count", count, 12);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("err_clr_alone", err, 0);

    // clr coinciding with a step pulse.
    pidx = 1;
    apply_phase(pidx);
    tick(7);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_step_pulse", step, 1);
    check("clr_step_count", count, 0);
    tick(3);
    pidx = 2;
    apply_phase(pidx);
    tick(10);
    check("post_clr_count", count, 1);

    // Reset in the middle of a pending transition.
    pidx = 3;
    apply_phase(pidx);
    tick(3);
    reset = 1'b1;
    tick(1);
    check("midrst_step", step, 0);
    check("midrst_dir", dir, 0);
    check("midrst_count", count, 0);
    check("midrst_err", err, 0);
    check("midrst_state", 32'(dut.state), 32'(S_INIT));
    tick(3);
    reset = 1'b0;
    s0 = step_cnt;
    tick(20);
    check("midrst_release_steps", step_cnt - s0, 0);
    check("midrst_release_err", err, 0);
    check("midrst_release_count", count, 0);

    // Randomized motion against the position model.
    m_count = 0;
    m_err   = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        s0 = step_cnt;
        if ($urandom_range(0, 1) == 1) a_in = ~a_in; else b_in = ~b_in;
        tick($urandom_range(1, 3));
        apply_phase(pidx);
        tick(8);
        check($sformatf("rnd%0d_glitch_steps", n), step_cnt - s0, 0);
      end
      r  = $urandom_range(0, 9);
      mv = (r == 0) ? 2 : ((r < 6) ? 1 : 3);
      pidx = (pidx + mv) % 4;
      apply_phase(pidx);
      hold = $urandom_range(10, 16);
      s0 = step_cnt;
      tick(hold);
      exp_steps = (mv == 2) ? 0 : 1;
      if (mv == 1) m_count = (m_count + 1) % 16;
      if (mv == 3) m_count = (m_count + 15) % 16;
      if (mv == 2) m_err = 1'b1;
      check($sformatf("rnd%0d_steps", n), step_cnt - s0, exp_steps);
      check($sformatf("rnd%0d_count", n), count, m_count);
      check($sformatf("rnd%0d_err", n), err, m_err);
      if (mv != 2) check($sformatf("rnd%0d_dir", n), last_dir, (mv == 1) ? 1 : 0);
      if (m_err && $urandom_range(0, 1) == 1) begin
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_err = 1'b0;
        check($sformatf("rnd%0d_errclr", n), err, 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_count = 0;
        check($sformatf("rnd%0d_clr", n), count, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
